bip_uart_ctrl: RTL and testbench

- Sits between the UART (rx/tx byte interfaces) and the BIP CPU.
- Waits for a start command byte from the host, then pulses the CPU `start` input and counts clock cycles until the CPU raises `cpu_done`.
- On `cpu_done` it snapshots the final program counter, accumulator/store data and cycle count, then transmits them to the host as a fixed 6-byte frame through the UART tx handshake.

---
 rtl/bip_uart_ctrl.sv | 144 ++++++++++++++
 tb/tb_bip_uart_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bip_uart_ctrl.sv
// Host-side run controller for the BIP CPU: waits for the start command over the UART,
// runs the CPU while counting cycles, then reports PC, accumulator and cycle count as a 6-byte frame.
module bip_uart_ctrl #(
  parameter int                       len_addr  = 11,
  parameter int                       len_data  = 16,
  parameter int                       len_count = 16,
  parameter int                       len_byte  = 8,
  parameter logic [len_byte-1:0]      cmd_start = 8'h53
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_done,
  input  logic [len_byte-1:0]  rx_data,
  input  logic                 tx_done,
  input  logic                 cpu_done,
  input  logic [len_addr-1:0]  pc,
  input  logic [len_data-1:0]  acc_data,
  output logic                 start,
  output logic                 tx_start,
  output logic [len_byte-1:0]  tx_data,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [2:0] last_index = 3'd5;

  state_t                state_reg, state_next;
  logic [2:0]            index_reg, index_next;
  logic [len_count-1:0]  count_reg, count_next;
  logic [len_addr-1:0]   pc_lat_reg, pc_lat_next;
  logic [len_data-1:0]   acc_lat_reg, acc_lat_next;
  logic [len_count-1:0]  cnt_lat_reg, cnt_lat_next;

  logic                  start_reg;
  logic                  tx_start_reg;
  logic [len_byte-1:0]   tx_data_reg;
  logic                  busy_reg;

  // Frame words are taken from the *next* latched values so the first byte can be
  // loaded on the same edge that captures the CPU result.
  logic [15:0]           frame_word [4];
  logic [len_byte-1:0]   frame_byte [8];

  assign frame_word[0] = 16'(pc_lat_next);
  assign frame_word[1] = 16'(acc_lat_next);
  assign frame_word[2] = 16'(cnt_lat_next);
  assign frame_word[3] = 16'h0000;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_frame
      assign frame_byte[2*gi]   = frame_word[gi][15:8];
      assign frame_byte[2*gi+1] = frame_word[gi][7:0];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    count_next   = count_reg;
    pc_lat_next  = pc_lat_reg;
    acc_lat_next = acc_lat_reg;
    cnt_lat_next = cnt_lat_reg;
    case (state_reg)
      IDLE: begin
        if (rx_done && (rx_data == cmd_start)) begin
          state_next = START;
        end
      end
      START: begin
        count_next = '0;
        state_next = RUN;
      end
      RUN: begin
        if (cpu_done) begin
          pc_lat_next  = pc;
          acc_lat_next = acc_data;
          cnt_lat_next = count_reg;
          index_next   = 3'd0;
          state_next   = SEND;
        end else if (count_reg != {len_count{1'b1}}) begin
          count_next = count_reg + 1'b1;
        end
      end
      SEND: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          if (index_reg == last_index) begin
            state_next = IDLE;
          end else begin
            index_next = index_reg + 3'd1;
            state_next = SEND;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      index_reg    <= 3'd0;
      count_reg    <= '0;
      pc_lat_reg   <= '0;
      acc_lat_reg  <= '0;
      cnt_lat_reg  <= '0;
      start_reg    <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      count_reg    <= count_next;
      pc_lat_reg   <= pc_lat_next;
      acc_lat_reg  <= acc_lat_next;
      cnt_lat_reg  <= cnt_lat_next;
      // Outputs follow the state being entered so each pulse lines up with its state.
      start_reg    <= (state_next == START);
      tx_start_reg <= (state_next == SEND);
      busy_reg     <= (state_next != IDLE);
      if (state_next == SEND) begin
        tx_data_reg <= frame_byte[index_next];
      end
    end
  end

  assign start    = start_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_bip_uart_ctrl.sv
// Directed bench for bip_uart_ctrl: command filtering, run/count, 6-byte frame,
// saturation, ignored stray handshakes and asynchronous abort.
module tb_bip_uart_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic        cpu_done;
  logic [10:0] pc;
  logic [15:0] acc_data;
  logic        start;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;
  int start_pulses = 0;
  int base_pulses;

  bip_uart_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .cpu_done (cpu_done),
    .pc       (pc),
    .acc_data (acc_data),
    .start    (start),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start === 1'b1) start_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue 'S' and step into the first RUN cycle.
  task automatic run_cmd(input string tag);
    rx_data = 8'h53;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check({tag, "_start_hi"}, 32'(start), 32'd1);
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_start_lo"}, 32'(start), 32'd0);
  endtask

  // Bounded wait for a tx_start pulse.
  task automatic wait_tx_start(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_tx_start_seen"}, 32'(found), 32'd1);
  endtask

  // Receive nbytes of a frame, answering each tx_start with tx_done 3 cycles later.
  task automatic recv_frame(input string tag, input logic [47:0] exp, input int nbytes, input bit inject);
    logic [7:0] eb;
    for (int i = 0; i < nbytes; i++) begin
      eb = exp[47-8*i -: 8];
      wait_tx_start($sformatf("%s_b%0d", tag, i));
      check($sformatf("%s_b%0d_data", tag, i), 32'(tx_data), 32'(eb));
      $display("tx byte %0d of %s: %02h (expected %02h)", i, tag, tx_data, eb);
      if (inject) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check($sformatf("%s_b%0d_pulse_lo", tag, i), 32'(tx_start), 32'd0);
      if (inject) begin
        rx_data = 8'h53;
        rx_done = 1'b1;
      end
      tick();
      rx_done = 1'b0;
      tick();
      tx_done = 1'b1;
      check($sformatf("%s_b%0d_hold", tag, i), 32'(tx_data), 32'(eb));
      tick();
      tx_done = 1'b0;
    end
    if (nbytes == 6) check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    tx_done  = 1'b0;
    cpu_done = 1'b0;
    pc       = 11'h000;
    acc_data = 16'h0000;
    tick();
    tick();
    check("rst_start", 32'(start), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // Non-command byte is ignored.
    rx_data = 8'h41;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("bad_cmd_start", 32'(start), 32'd0);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    tick();
    check("bad_cmd_busy2", 32'(busy), 32'd0);
    check("bad_cmd_pulses", 32'(start_pulses), 32'd0);

    // Basic run: 10 RUN cycles before cpu_done.
    pc = 11'h005;
    acc_data = 16'h00AB;
    base_pulses = start_pulses;
    run_cmd("basic");
    repeat (10) tick();
    check("basic_run_no_tx", 32'(tx_start), 32'd0);
    cpu_done = 1'b1;
    tick();
    check("basic_tx_latency", 32'(tx_start), 32'd1);
    cpu_done = 1'b0;
    recv_frame("basic", 48'h00_05_00_AB_00_0A, 6, 1'b0);
    check("basic_one_start", 32'(start_pulses - base_pulses), 32'd1);

    // cpu_done already high on RUN entry; inputs change after the latch.
    pc = 11'h7FF;
    acc_data = 16'h1234;
    cpu_done = 1'b1;
    run_cmd("imm");
    tick();
    pc = 11'h000;
    acc_data = 16'h0000;
    cpu_done = 1'b0;
    recv_frame("imm", 48'h07_FF_12_34_00_00, 6, 1'b0);

    // Saturating counter.
    pc = 11'h3AB;
    acc_data = 16'hBEEF;
    run_cmd("sat");
    repeat (70000) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    recv_frame("sat", 48'h03_AB_BE_EF_FF_FF, 6, 1'b0);

    // Stray rx_done during RUN/WAIT_TX and tx_done during SEND.
    pc = 11'h123;
    acc_data = 16'h5A5A;
    base_pulses = start_pulses;
    run_cmd("stray");
    rx_data = 8'h53;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    recv_frame("stray", 48'h01_23_5A_5A_00_03, 6, 1'b1);
    check("stray_one_start", 32'(start_pulses - base_pulses), 32'd1);

    // Abort during WAIT_TX of byte 2, then a fresh run.
    pc = 11'h0FF;
    acc_data = 16'hCAFE;
    cpu_done = 1'b1;
    run_cmd("abort");
    tick();
    cpu_done = 1'b0;
    recv_frame("abort", 48'h00_FF_CA_FE_00_00, 2, 1'b0);
    wait_tx_start("abort_b2");
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_start", 32'(tx_start), 32'd0);
    check("abort_start", 32'(start), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_abort_idle", 32'(busy), 32'd0);
    pc = 11'h456;
    acc_data = 16'h0102;
    run_cmd("fresh");
    repeat (2) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    recv_frame("fresh", 48'h04_56_01_02_00_02, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
